// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder bit per clock, LSB first, carry held in c_q.
// Optional subtract mode (sub port, a - b) is built only when SERIAL_ADDER_SUB_EN is defined.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   r_sh_q, r_sh_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               c_q, c_d;
    logic               cout_q, cout_d;
    logic               done_q, done_d;

    logic               bit_s;
    logic               bit_co;
    logic [WIDTH-1:0]   b_load;
    logic               c_load;

    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | (y & c) | (c & x);
    endfunction

    assign bit_s  = fa_sum(a_sh_q[0], b_sh_q[0], c_q);
    assign bit_co = fa_carry(a_sh_q[0], b_sh_q[0], c_q);

    // Subtraction is a + ~b + 1, so cin is ignored when sub is set.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        r_sh_d  = r_sh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b_load;
                    c_d     = c_load;
                    cnt_d   = '0;
                    r_sh_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                r_sh_d = {bit_s, r_sh_q[WIDTH-1:1]};
                c_d    = bit_co;
                a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CNT_W'(1);
                // The last bit goes straight into sum; r_sh is not reread afterwards.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    sum_d   = {bit_s, r_sh_q[WIDTH-1:1]};
                    cout_d  = bit_co;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            r_sh_q  <= r_sh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): expected {cout,sum} queued at start, checked at done.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub = 1'b0;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int passed = 0;
    logic [W:0] exp_q[$];

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (sum !== 8'h00) $display("FAIL reset_sum got=%h exp=00", sum); else passed++;
        checks++; if (cout !== 1'b0) $display("FAIL reset_cout got=%b exp=0", cout); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passed++;
    endtask

    task automatic test_add();
        logic [W-1:0] ta[7];
        logic [W-1:0] tb[7];
        logic         tc[7];
        logic [W:0]   e;
        int lat;
        bit got;
        ta[0] = 8'hFF; tb[0] = 8'h01; tc[0] = 1'b0;
        ta[1] = 8'hA5; tb[1] = 8'h5A; tc[1] = 1'b1;
        ta[2] = 8'h3C; tb[2] = 8'h0F; tc[2] = 1'b0;
        ta[3] = 8'h00; tb[3] = 8'h00; tc[3] = 1'b0;
        for (int i = 4; i < 7; i++) begin
            ta[i] = W'($urandom);
            tb[i] = W'($urandom);
            tc[i] = 1'($urandom);
        end
        for (int i = 0; i < 7; i++) begin
            a = ta[i]; b = tb[i]; cin = tc[i]; start = 1'b1;
            exp_q.push_back({1'b0, ta[i]} + {1'b0, tb[i]} + {{W{1'b0}}, tc[i]});
            @(posedge clk); #1;
            start = 1'b0;
            checks++; if (busy !== 1'b1) $display("FAIL add%0d_busy got=%b exp=1", i, busy); else passed++;
            got = 0; lat = 0;
            for (int k = 1; k <= 20 && !got; k++) begin
                @(posedge clk); #1;
                if (done) begin got = 1; lat = k; end
            end
            e = exp_q.pop_front();
            checks++;
            if (!got) $display("FAIL add%0d_timeout got=no_done exp=done", i);
            else if (lat != W) $display("FAIL add%0d_latency got=%0d exp=%0d", i, lat, W);
            else passed++;
            checks++; if ({cout, sum} !== e) $display("FAIL add%0d_result got=%h exp=%h", i, {cout, sum}, e); else passed++;
            checks++; if (busy !== 1'b0) $display("FAIL add%0d_busy_at_done got=%b exp=0", i, busy); else passed++;
            @(posedge clk); #1;
            checks++; if (done !== 1'b0) $display("FAIL add%0d_done_width got=%b exp=0", i, done); else passed++;
        end
    endtask

    task automatic test_start_ignored();
        logic [W:0] prev;
        logic [W:0] e;
        int ndone = 0;
        int unstable = 0;
        prev = {cout, sum};
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        exp_q.push_back(9'h002);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            if (k == 3) begin a = 8'hFF; b = 8'hFF; start = 1'b1; end
            if (k == 4) start = 1'b0;
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                e = exp_q.pop_front();
                checks++; if ({cout, sum} !== e) $display("FAIL ignore_result got=%h exp=%h", {cout, sum}, e); else passed++;
            end else if (ndone == 0 && {cout, sum} !== prev) unstable++;
        end
        checks++; if (ndone != 1) $display("FAIL ignore_done_count got=%0d exp=1", ndone); else passed++;
        checks++; if (unstable != 0) $display("FAIL ignore_sum_hold got=%0d_changes exp=0", unstable); else passed++;
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [W:0] e;
        int ndone = 0;
        int last = 0;
        int bad_gap = 0;
        int bad_busy = 0;
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        repeat (3) exp_q.push_back(9'h030);
        @(posedge clk); #1;
        for (int k = 1; k <= 27; k++) begin
            @(posedge clk); #1;
            if (busy === done) bad_busy++;
            if (done) begin
                if (ndone == 0 ? (k != W) : (k - last != W + 1)) bad_gap++;
                last = k;
                ndone++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
                checks++; if ({cout, sum} !== e) $display("FAIL b2b_result%0d got=%h exp=%h", ndone, {cout, sum}, e); else passed++;
            end
        end
        start = 1'b0;
        checks++; if (ndone != 3) $display("FAIL b2b_done_count got=%0d exp=3", ndone); else passed++;
        checks++; if (bad_gap != 0) $display("FAIL b2b_spacing got=%0d_bad exp=0", bad_gap); else passed++;
        checks++; if (bad_busy != 0) $display("FAIL b2b_busy_vs_done got=%0d_bad exp=0", bad_busy); else passed++;
        exp_q.delete();
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_abort();
        logic [W:0] e;
        int lat = 0;
        int spurious = 0;
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        exp_q.push_back(9'h046);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({busy, done, cout, sum} !== 11'h0) $display("FAIL abort_outputs got=%h exp=000", {busy, done, cout, sum}); else passed++;
        exp_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (done || busy) spurious++;
        end
        checks++; if (spurious != 0) $display("FAIL abort_no_done got=%0d exp=0", spurious); else passed++;
        a = 8'h12; b = 8'h34; cin = 1'b1; start = 1'b1;
        exp_q.push_back(9'h047);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (done) lat = k;
        end
        e = exp_q.pop_front();
        checks++; if (lat != W) $display("FAIL abort_next_latency got=%0d exp=%0d", lat, W); else passed++;
        checks++; if ({cout, sum} !== e) $display("FAIL abort_next_result got=%h exp=%h", {cout, sum}, e); else passed++;
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        logic [W-1:0] ta[3];
        logic [W-1:0] tb[3];
        logic         tc[3];
        logic [W:0]   e;
        int lat;
        ta[0] = 8'h10; tb[0] = 8'h01; tc[0] = 1'b0;
        ta[1] = 8'h00; tb[1] = 8'h01; tc[1] = 1'b1;
        ta[2] = 8'h10; tb[2] = 8'h01; tc[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = ta[i]; b = tb[i]; cin = tc[i]; sub = 1'b1; start = 1'b1;
            exp_q.push_back({1'b0, ta[i]} + {1'b0, ~tb[i]} + 9'd1);
            @(posedge clk); #1;
            start = 1'b0;
            lat = 0;
            for (int k = 1; k <= 20 && lat == 0; k++) begin
                @(posedge clk); #1;
                if (done) lat = k;
            end
            e = exp_q.pop_front();
            checks++; if (lat != W) $display("FAIL sub%0d_latency got=%0d exp=%0d", i, lat, W); else passed++;
            checks++; if ({cout, sum} !== e) $display("FAIL sub%0d_result got=%h exp=%h", i, {cout, sum}, e); else passed++;
        end
        sub = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_start_ignored();
        test_back_to_back();
        test_reset_abort();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
